// File: rtl/qr_uart_tx_if.sv
// Handshake and payload bundle between the QR decode stage and the UART transmitter.
// The master drives the captured decode outputs and start; the slave returns line and status.
interface qr_uart_tx_if;
   logic       start_in;
   logic [3:0] data_type_in;
   logic [7:0] data_length_in;
   logic [7:0] bytes_in [18:0];
   logic       uart_tx_out;
   logic       busy_out;
   logic       done_out;
   logic       error_out;

   modport master (
      output start_in, data_type_in, data_length_in, bytes_in,
      input  uart_tx_out, busy_out, done_out, error_out
   );

   modport slave (
      input  start_in, data_type_in, data_length_in, bytes_in,
      output uart_tx_out, busy_out, done_out, error_out
   );
endinterface

// File: rtl/qr_uart_tx.sv
// Sends one captured QR v1 payload to the host as 8N1 frames:
// the clamped length byte, the payload bytes, then a 0x0A terminator.
module qr_uart_tx #(
   parameter int BAUD_DIV  = 868,
   parameter int MAX_BYTES = 17
) (
   input  logic         clk_in,
   input  logic         rst_in,
   qr_uart_tx_if.slave  bus
);

   localparam logic [15:0] BAUD_LAST  = 16'(BAUD_DIV - 1);
   localparam logic [7:0]  MAX_LEN    = 8'(MAX_BYTES);
   localparam logic [3:0]  BYTE_MODE  = 4'b0100;
   localparam logic [7:0]  TERMINATOR = 8'h0A;

   // The "next byte" decision is folded into the last STOP_BIT cycle, so it has no encoding.
   typedef enum logic [2:0] {
      IDLE, CHECK, START_BIT, DATA_BITS, STOP_BIT, FINISH
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] baud_q, baud_d;
   logic [2:0]  bit_q, bit_d;
   logic [4:0]  idx_q, idx_d;
   logic [4:0]  n_q, n_d;
   logic        err_q, err_d;
   logic        tx_q, tx_d;
   logic [3:0]  type_q, type_d;
   logic [7:0]  len_q, len_d;
   logic [7:0]  bytes_q [19];
   logic [7:0]  bytes_d [19];
   logic        baud_wrap;
   logic [4:0]  byte_sel;
   logic [7:0]  cur_byte;
   logic        busy, done, error;

   function automatic logic [4:0] clamp_len(input logic [7:0] len);
      if (len > MAX_LEN) return MAX_LEN[4:0];
      return len[4:0];
   endfunction

   assign baud_wrap = (baud_q == BAUD_LAST);

   always_ff @(posedge clk_in) begin
      if (rst_in) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      idx_d   = idx_q;
      n_d     = n_q;
      err_d   = err_q;
      type_d  = type_q;
      len_d   = len_q;
      for (int i = 0; i < 19; i++) bytes_d[i] = bytes_q[i];

      case (state_q)
         IDLE: begin
            baud_d = '0;
            bit_d  = '0;
            idx_d  = '0;
            if (bus.start_in) begin
               state_d = CHECK;
               err_d   = 1'b0;
               type_d  = bus.data_type_in;
               len_d   = bus.data_length_in;
               for (int i = 0; i < 19; i++) bytes_d[i] = bus.bytes_in[i];
            end
         end
         CHECK: begin
            baud_d = '0;
            if (type_q != BYTE_MODE) begin
               err_d   = 1'b1;
               state_d = FINISH;
            end else begin
               n_d     = clamp_len(len_q);
               state_d = START_BIT;
            end
         end
         START_BIT: begin
            baud_d = baud_wrap ? '0 : baud_q + 16'd1;
            if (baud_wrap) begin
               bit_d   = '0;
               state_d = DATA_BITS;
            end
         end
         DATA_BITS: begin
            baud_d = baud_wrap ? '0 : baud_q + 16'd1;
            if (baud_wrap) begin
               if (bit_q == 3'd7) state_d = STOP_BIT;
               else               bit_d   = bit_q + 3'd1;
            end
         end
         STOP_BIT: begin
            baud_d = baud_wrap ? '0 : baud_q + 16'd1;
            // Queue holds n+2 entries: length byte, n payload bytes, terminator.
            if (baud_wrap) begin
               if (idx_q == n_q + 5'd1) begin
                  state_d = FINISH;
               end else begin
                  idx_d   = idx_q + 5'd1;
                  state_d = START_BIT;
               end
            end
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy     = (state_q != IDLE) && (state_q != FINISH);
      done     = (state_q == FINISH);
      error    = (state_q == FINISH) && err_q;
      byte_sel = idx_d - 5'd1;
      cur_byte = TERMINATOR;
      if (idx_d == 5'd0)     cur_byte = {3'b000, n_q};
      else if (idx_d <= n_q) cur_byte = bytes_q[byte_sel];
      // The line is driven from the next state so the serial output is a clean flop.
      case (state_d)
         START_BIT: tx_d = 1'b0;
         DATA_BITS: tx_d = cur_byte[bit_d];
         default:   tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         baud_q <= '0;
         bit_q  <= '0;
         idx_q  <= '0;
         err_q  <= 1'b0;
         tx_q   <= 1'b1;
      end else begin
         baud_q <= baud_d;
         bit_q  <= bit_d;
         idx_q  <= idx_d;
         err_q  <= err_d;
         tx_q   <= tx_d;
      end
   end

   // Capture register and clamped count carry no reset; they are reloaded before use.
   always_ff @(posedge clk_in) begin
      type_q <= type_d;
      len_q  <= len_d;
      n_q    <= n_d;
      for (int i = 0; i < 19; i++) bytes_q[i] <= bytes_d[i];
   end

   assign bus.uart_tx_out = tx_q;
   assign bus.busy_out    = busy;
   assign bus.done_out    = done;
   assign bus.error_out   = error;

endmodule

// File: tb/tb_qr_uart_tx.sv
// Bench for qr_uart_tx: randomized payloads checked against a queue-based model of the
// transmitted byte stream, an ideal per-cycle line waveform and a mid-bit UART receiver.
module tb_qr_uart_tx;
   localparam int B    = 4;
   localparam int MAXB = 17;
   localparam int FR   = 10 * B;
   localparam int BUDGET = 2 + FR * (MAXB + 2) + 20;

   typedef logic [7:0] arr_t [19];

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   qr_uart_tx_if bus ();
   qr_uart_tx #(.BAUD_DIV(B), .MAX_BYTES(MAXB)) dut (
      .clk_in (clk),
      .rst_in (rst),
      .bus    (bus)
   );

   int errors = 0;
   int checks = 0;

   logic       tx_s[$], busy_s[$], done_s[$], err_s[$];
   logic [7:0] exp_q[$], rx_q[$];
   int         done_at, extra_done, wave_mis, ctl_mis, framing, rx_bad;
   logic       err_at_done;

   task automatic drive_bytes(input arr_t b);
      for (int i = 0; i < 19; i++) bus.bytes_in[i] = b[i];
   endtask

   task automatic random_bytes(output arr_t b);
      for (int i = 0; i < 19; i++) b[i] = 8'($urandom);
   endtask

   // Reference: what the host should receive for a given capture.
   task automatic build_expected(input logic [3:0] typ, input logic [7:0] len, input arr_t b);
      int n;
      exp_q.delete();
      if (typ != 4'b0100) return;
      n = (int'(len) > MAXB) ? MAXB : int'(len);
      exp_q.push_back(8'(n));
      for (int i = 0; i < n; i++) exp_q.push_back(b[i]);
      exp_q.push_back(8'h0A);
   endtask

   task automatic record();
      tx_s.push_back(bus.uart_tx_out);
      busy_s.push_back(bus.busy_out);
      done_s.push_back(bus.done_out);
      err_s.push_back(bus.error_out);
   endtask

   // Sample k=0 is the cycle carrying start_in; sample k is k cycles later.
   task automatic send(input logic [3:0] typ, input logic [7:0] len, input arr_t b, input int poke_k);
      arr_t junk;
      tx_s.delete(); busy_s.delete(); done_s.delete(); err_s.delete();
      @(negedge clk);
      bus.start_in       = 1'b1;
      bus.data_type_in   = typ;
      bus.data_length_in = len;
      drive_bytes(b);
      record();
      done_at = -1;
      for (int k = 1; k <= BUDGET; k++) begin
         @(negedge clk);
         record();
         bus.start_in = (k == poke_k);
         if (k == 1 || k == poke_k) begin
            random_bytes(junk);
            drive_bytes(junk);
            bus.data_length_in = 8'($urandom);
            bus.data_type_in   = (k == poke_k) ? 4'b0100 : 4'($urandom);
         end
         if (bus.done_out === 1'b1) begin
            done_at = k;
            break;
         end
      end
      bus.start_in = 1'b0;
      extra_done = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (bus.done_out !== 1'b0) extra_done++;
      end
   endtask

   task automatic analyse();
      int   exp_done, rel, f, j;
      logic e;
      logic [7:0] by;
      exp_done = 2 + FR * exp_q.size();
      wave_mis = 0; ctl_mis = 0; framing = 0; rx_bad = 0;
      for (int k = 0; k < tx_s.size(); k++) begin
         rel = k - 2;
         e = 1'b1;
         if (k >= 2 && rel < FR * exp_q.size()) begin
            f = rel / FR;
            j = (rel % FR) / B;
            by = exp_q[f];
            if (j == 0)      e = 1'b0;
            else if (j == 9) e = 1'b1;
            else             e = by[j-1];
         end
         if (tx_s[k] !== e) wave_mis++;
         if (busy_s[k] !== (k >= 1 && k < exp_done)) ctl_mis++;
         if (k != done_at && err_s[k] !== 1'b0) ctl_mis++;
      end
      err_at_done = (done_at >= 0) ? err_s[done_at] : 1'bx;
      rx_q.delete();
      for (int k = 0; k < tx_s.size(); ) begin
         if (tx_s[k] === 1'b0) begin
            if (k + FR > tx_s.size()) begin framing++; break; end
            for (int b = 0; b < 8; b++) by[b] = tx_s[k + (b + 1) * B + B / 2];
            if (tx_s[k + 9 * B + B / 2] !== 1'b1) framing++;
            rx_q.push_back(by);
            k += FR;
         end else begin
            k++;
         end
      end
      if (rx_q.size() != exp_q.size()) rx_bad = 1;
      else for (int i = 0; i < rx_q.size(); i++) if (rx_q[i] !== exp_q[i]) rx_bad++;
   endtask

   task automatic test_reset();
      int bad = 0;
      rst = 1'b1;
      bus.start_in = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (bus.uart_tx_out !== 1'b1) begin errors++; $display("FAIL rst_tx: got %b want 1", bus.uart_tx_out); end
      checks++; if (bus.busy_out !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.busy_out); end
      checks++; if (bus.done_out !== 1'b0 || bus.error_out !== 1'b0) begin errors++; $display("FAIL rst_done_err: got %b%b want 00", bus.done_out, bus.error_out); end
      rst = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (bus.uart_tx_out !== 1'b1 || bus.busy_out !== 1'b0 || bus.done_out !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL idle_100: got %0d bad cycles want 0", bad); end
   endtask

   task automatic test_byte_mode();
      arr_t b;
      random_bytes(b);
      b[0] = 8'h41; b[1] = 8'h42; b[2] = 8'h43;
      build_expected(4'b0100, 8'd3, b);
      send(4'b0100, 8'd3, b, 0);
      analyse();
      checks++; if (done_at != 202) begin errors++; $display("FAIL bm_done_cycle: got %0d want 202", done_at); end
      checks++; if (err_at_done !== 1'b0) begin errors++; $display("FAIL bm_error: got %b want 0", err_at_done); end
      checks++; if (rx_q.size() != 5 || rx_q[0] !== 8'h03 || rx_q[1] !== 8'h41 || rx_q[4] !== 8'h0A)
         begin errors++; $display("FAIL bm_rx: got %0d bytes first %h want 5 bytes 03 41 42 43 0a", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx); end
      checks++; if (wave_mis != 0 || framing != 0) begin errors++; $display("FAIL bm_wave: got %0d/%0d bad want 0/0", wave_mis, framing); end
      checks++; if (ctl_mis != 0) begin errors++; $display("FAIL bm_busy: got %0d bad cycles want 0", ctl_mis); end
      checks++; if (extra_done != 0) begin errors++; $display("FAIL bm_extra_done: got %0d want 0", extra_done); end
   endtask

   task automatic test_non_byte();
      arr_t b;
      random_bytes(b);
      build_expected(4'b0010, 8'd5, b);
      send(4'b0010, 8'd5, b, 0);
      analyse();
      checks++; if (done_at != 2) begin errors++; $display("FAIL nb_done_cycle: got %0d want 2", done_at); end
      checks++; if (err_at_done !== 1'b1) begin errors++; $display("FAIL nb_error: got %b want 1", err_at_done); end
      checks++; if (wave_mis != 0 || rx_q.size() != 0) begin errors++; $display("FAIL nb_line_low: got %0d bad, %0d frames want 0", wave_mis, rx_q.size()); end
      checks++; if (ctl_mis != 0) begin errors++; $display("FAIL nb_busy: got %0d bad cycles want 0", ctl_mis); end
   endtask

   task automatic test_clamp();
      arr_t b;
      for (int i = 0; i < 19; i++) b[i] = 8'(i);
      build_expected(4'b0100, 8'd25, b);
      send(4'b0100, 8'd25, b, 0);
      analyse();
      checks++; if (rx_q.size() != 19 || rx_q[0] !== 8'h11 || rx_q[17] !== 8'h10 || rx_q[18] !== 8'h0A)
         begin errors++; $display("FAIL clamp_rx: got %0d frames len %h want 19 frames len 11", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx); end
      checks++; if (rx_bad != 0) begin errors++; $display("FAIL clamp_model: got %0d bad bytes want 0", rx_bad); end
      checks++; if (done_at != 2 + FR * 19) begin errors++; $display("FAIL clamp_done: got %0d want %0d", done_at, 2 + FR * 19); end
   endtask

   task automatic test_len_zero();
      arr_t b;
      random_bytes(b);
      build_expected(4'b0100, 8'd0, b);
      send(4'b0100, 8'd0, b, 0);
      analyse();
      checks++; if (rx_q.size() != 2 || rx_q[0] !== 8'h00 || rx_q[1] !== 8'h0A)
         begin errors++; $display("FAIL zero_rx: got %0d frames want 2 (00 0a)", rx_q.size()); end
      checks++; if (done_at != 2 + FR * 2 || wave_mis != 0) begin errors++; $display("FAIL zero_timing: got done %0d wave %0d want %0d/0", done_at, wave_mis, 2 + FR * 2); end
   endtask

   task automatic test_random();
      arr_t b;
      logic [3:0] typ;
      logic [7:0] len;
      for (int t = 0; t < 5; t++) begin
         random_bytes(b);
         typ = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0100;
         len = 8'($urandom_range(0, 30));
         build_expected(typ, len, b);
         send(typ, len, b, 0);
         analyse();
         checks++; if (done_at != 2 + FR * exp_q.size()) begin errors++; $display("FAIL rnd%0d_done: got %0d want %0d", t, done_at, 2 + FR * exp_q.size()); end
         checks++; if (err_at_done !== (typ != 4'b0100)) begin errors++; $display("FAIL rnd%0d_error: got %b want %b", t, err_at_done, typ != 4'b0100); end
         checks++; if (rx_bad != 0 || wave_mis != 0 || framing != 0) begin errors++; $display("FAIL rnd%0d_data: got %0d/%0d/%0d bad want 0", t, rx_bad, wave_mis, framing); end
         checks++; if (ctl_mis != 0 || extra_done != 0) begin errors++; $display("FAIL rnd%0d_ctl: got %0d/%0d want 0/0", t, ctl_mis, extra_done); end
      end
   endtask

   task automatic test_ignore_start();
      arr_t b;
      random_bytes(b);
      build_expected(4'b0100, 8'd6, b);
      send(4'b0100, 8'd6, b, 57);
      analyse();
      checks++; if (rx_bad != 0 || wave_mis != 0) begin errors++; $display("FAIL ign_data: got %0d/%0d bad want 0/0", rx_bad, wave_mis); end
      checks++; if (done_at != 2 + FR * 8 || extra_done != 0) begin errors++; $display("FAIL ign_done: got %0d extra %0d want %0d/0", done_at, extra_done, 2 + FR * 8); end
   endtask

   task automatic test_reset_midframe();
      arr_t b;
      int   seen_done = 0;
      int   target = 2 + FR + B * 3 + 1;
      random_bytes(b);
      @(negedge clk);
      bus.start_in = 1'b1; bus.data_type_in = 4'b0100; bus.data_length_in = 8'd4;
      drive_bytes(b);
      for (int k = 1; k <= target; k++) begin
         @(negedge clk);
         bus.start_in = 1'b0;
         if (bus.done_out !== 1'b0) seen_done++;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (bus.uart_tx_out !== 1'b1 || bus.busy_out !== 1'b0) begin errors++; $display("FAIL midrst_out: got tx %b busy %b want 1 0", bus.uart_tx_out, bus.busy_out); end
      if (bus.done_out !== 1'b0) seen_done++;
      repeat (4) begin
         @(negedge clk);
         if (bus.done_out !== 1'b0 || bus.uart_tx_out !== 1'b1) seen_done++;
      end
      checks++; if (seen_done != 0) begin errors++; $display("FAIL midrst_no_done: got %0d events want 0", seen_done); end
      random_bytes(b);
      build_expected(4'b0100, 8'd4, b);
      send(4'b0100, 8'd4, b, 0);
      analyse();
      checks++; if (rx_bad != 0 || wave_mis != 0 || done_at != 2 + FR * 6) begin errors++; $display("FAIL midrst_resend: got %0d/%0d done %0d want 0/0 done %0d", rx_bad, wave_mis, done_at, 2 + FR * 6); end
   endtask

   initial begin
      bus.start_in = 1'b0;
      bus.data_type_in = '0;
      bus.data_length_in = '0;
      for (int i = 0; i < 19; i++) bus.bytes_in[i] = '0;
      test_reset();
      test_byte_mode();
      test_non_byte();
      test_clamp();
      test_len_zero();
      test_random();
      test_ignore_start();
      test_reset_midframe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/qr_uart_tx.md
Name: qr_uart_tx

Overview:
- Downstream of the QR data-decode stage.
- Captures one decoded QR version-1 payload (mode nibble, length byte, 19 data bytes) on a start pulse.
- Streams the payload out of the FPGA as 8N1 UART frames to the host PC: length byte, then the payload bytes, then a 0x0A terminator.
- Sequential: capture register, byte sequencer FSM, baud counter, bit counter.

Parameters:
- BAUD_DIV, 868, clock cycles per UART bit (100 MHz / 115200); legal range 2..65535.
- MAX_BYTES, 17, maximum payload bytes transmitted (byte-mode capacity for version 1-L); legal range 1..19.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous, active-high reset
- start_in  input  1  single-cycle request to capture and transmit the current decode outputs
- data_type_in  input  4  decoded mode indicator
- data_length_in  input  8  decoded character count
- bytes_in  input  8 x 19 (unpacked array [18:0])  decoded data bytes; index 0 is sent first
- uart_tx_out  output  1  serial line; idles high
- busy_out  output  1  high from the cycle after an accepted start until done_out
- done_out  output  1  one-cycle pulse when a transaction ends
- error_out  output  1  one-cycle pulse, coincident with done_out, when mode is not byte mode (4'b0100)

Behaviour:
- Reset (rst_in high at a clock edge):
  - Next cycle: uart_tx_out=1, busy_out=0, done_out=0, error_out=0.
  - FSM returns to IDLE; all counters clear; the capture register is don't-care.
  - Reset mid-frame aborts the transaction immediately, with no done_out.
- FSM states: IDLE, CHECK, START_BIT, DATA_BITS, STOP_BIT, NEXT, FINISH.
- IDLE:
  - uart_tx_out=1.
  - start_in=1 latches data_type_in, data_length_in and all 19 bytes_in into internal registers; go to CHECK.
  - busy_out=1 from the next cycle.
- start_in while busy is ignored and does not alter the captured data.
- CHECK (one cycle):
  - If data_type != 4'b0100: go to FINISH with the error flag set; no UART frames are emitted.
  - Otherwise: n = min(data_length, MAX_BYTES), computed unsigned 8-bit.
  - Send queue = [n, byte0 .. byte(n-1), 8'h0A]; queue length n+2.
  - Go to START_BIT.
- Frame format:
  - START_BIT drives 0 for BAUD_DIV cycles.
  - DATA_BITS drives bits 0..7, LSB first, BAUD_DIV cycles each.
  - STOP_BIT drives 1 for BAUD_DIV cycles.
  - Frame length is exactly 10*BAUD_DIV cycles.
  - Baud counter counts 0..BAUD_DIV-1 and wraps; the bit index advances on wrap.
- NEXT (zero cycles; merged into the last STOP_BIT cycle):
  - If more queue entries remain, the next START_BIT begins immediately. Frames are back-to-back with no extra idle cycles.
  - Otherwise go to FINISH.
- FINISH (one cycle):
  - done_out=1; error_out=1 if the error flag is set.
  - busy_out drops to 0 in the same cycle; return to IDLE.
  - A start_in in the FINISH cycle is ignored; start_in is accepted from the next cycle.
- Boundary cases:
  - data_length=0: sends 0x00, 0x0A (2 frames).
  - data_length > MAX_BYTES: clamped. The length byte sent equals the clamped n, not the raw value.
- Latency:
  - First start-bit falling edge on uart_tx_out appears 2 cycles after the start_in edge (capture, CHECK).
  - Total busy duration = 2 + 10*BAUD_DIV*(n+2) cycles, measured to the done_out cycle.
- uart_tx_out is registered (glitch-free).
- Inputs are sampled only at the accepted start, so they may change during transmission.

Test Plan:
- Reset then idle, BAUD_DIV=4 -> uart_tx_out=1, busy_out=0, done_out=0 for 100 cycles; start_in never asserted.
- BAUD_DIV=4, type=4'b0100, length=3, bytes 0x41,0x42,0x43 -> UART decoder receives 0x03,0x41,0x42,0x43,0x0A. Each frame is 40 cycles, back-to-back. done_out pulses once, 2+200 cycles after start; error_out=0.
- type=4'b0010 (alphanumeric), length=5 -> no low level ever on uart_tx_out. done_out and error_out pulse together 2 cycles after start; busy_out high exactly during CHECK and FINISH span.
- type=4'b0100, length=25, bytes = 0x00..0x12 -> length byte sent is 0x11, followed by 0x00..0x10 (17 bytes), then 0x0A; 19 frames total.
- During transmission, pulse start_in again and change bytes_in -> second start ignored; transmitted data matches the first capture; a single done_out.
- Assert rst_in mid-DATA_BITS of the 2nd frame -> uart_tx_out=1 and busy_out=0 the next cycle, no done_out. A new start 5 cycles later transmits a full, correct sequence.
